pwm_reg_ctrl: RTL and testbench



---
 rtl/pwm_reg_pkg.sv | 26 ++
 rtl/cdc_sync_bit.sv | 24 ++
 rtl/pwm_reg_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pwm_reg_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_reg_pkg.sv
// Shared constants and types for the PWM register controller.
package pwm_reg_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned CNT_W  = 4;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_DUTY   = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_INV_BIT     = 1;
    localparam int unsigned STATUS_PEND_BIT  = 0;
    localparam int unsigned STATUS_CLAMP_BIT = 1;
    localparam int unsigned STATUS_CNT_LSB   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        APPLY    = 2'd2,
        WAIT_REL = 2'd3
    } wr_state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop level synchroniser for a single control bit.
module cdc_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    // Shift the asynchronous level through the flop chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/pwm_reg_ctrl.sv
// Register bank between the SPI slave and the PWM core, with shadowed
// PERIOD/DUTY that only reach the PWM at a cycle boundary.
module pwm_reg_ctrl
    import pwm_reg_pkg::*;
#(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RST_PERIOD  = 8'hFF,
    parameter logic [DATA_W-1:0] RST_DUTY    = 8'h80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_wr_en,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_data,
    output logic [DATA_W-1:0] rd_data,
    input  logic              pwm_cycle_end,
    output logic              pwm_en,
    output logic              pwm_inv,
    output logic [DATA_W-1:0] pwm_period,
    output logic [DATA_W-1:0] pwm_duty
);

    logic              wr_sync;
    wr_state_t         state;
    wr_state_t         state_nxt;
    logic              cap_en;
    logic              apply_en;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic [1:0]        ctrl_q;
    logic [DATA_W-1:0] sh_period;
    logic [DATA_W-1:0] sh_duty;
    logic [DATA_W-1:0] act_period;
    logic [DATA_W-1:0] act_duty;
    logic              pending;
    logic [CNT_W-1:0]  wr_cnt;
    logic              clamp_active;
    logic              boundary;
    logic              shadow_wr;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] rd_mux;

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .clk (clk),
        .rst (rst),
        .d   (spi_wr_en),
        .q   (wr_sync)
    );

    // Write FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write FSM next state; a strobe gone before capture completes is dropped
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (wr_sync) state_nxt = CAPTURE;
            CAPTURE:  state_nxt = wr_sync ? APPLY : IDLE;
            APPLY:    state_nxt = WAIT_REL;
            WAIT_REL: if (!wr_sync) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Write FSM outputs
    always_comb begin
        cap_en   = 1'b0;
        apply_en = 1'b0;
        case (state)
            CAPTURE: cap_en   = wr_sync;
            APPLY:   apply_en = 1'b1;
            default: ;
        endcase
    end

    // Capture the SPI address/data once the strobe is confirmed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_addr <= '0;
            cap_data <= '0;
        end else if (cap_en) begin
            cap_addr <= spi_addr;
            cap_data <= spi_data;
        end
    end

    // Commit the captured write into CTRL or the shadows and count it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= '0;
            sh_period <= RST_PERIOD;
            sh_duty   <= RST_DUTY;
            wr_cnt    <= '0;
        end else if (apply_en) begin
            case (cap_addr)
                ADDR_CTRL:   ctrl_q    <= cap_data[1:0];
                ADDR_PERIOD: sh_period <= cap_data;
                ADDR_DUTY:   sh_duty   <= cap_data;
                default: ;
            endcase
            if (cap_addr != ADDR_STATUS) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

    assign shadow_wr = apply_en && ((cap_addr == ADDR_PERIOD) || (cap_addr == ADDR_DUTY));
    assign boundary  = pending && (pwm_cycle_end || !ctrl_q[CTRL_EN_BIT]);

    // Move shadows to actives at a boundary; a same-cycle write re-arms pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_period <= RST_PERIOD;
            act_duty   <= RST_DUTY;
            pending    <= 1'b0;
        end else begin
            if (boundary) begin
                act_period <= sh_period;
                act_duty   <= sh_duty;
            end
            if (shadow_wr) begin
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    assign clamp_active = act_duty > act_period;
    assign pwm_duty     = clamp_active ? act_period : act_duty;
    assign pwm_period   = act_period;
    assign pwm_en       = ctrl_q[CTRL_EN_BIT];
    assign pwm_inv      = ctrl_q[CTRL_INV_BIT];

    // Assemble the read-only status byte
    always_comb begin
        status = '0;
        status[STATUS_PEND_BIT]                     = pending;
        status[STATUS_CLAMP_BIT]                    = clamp_active;
        status[STATUS_CNT_LSB +: CNT_W]             = wr_cnt;
    end

    // Select read data for the current SPI address
    always_comb begin
        rd_mux = '0;
        case (spi_addr)
            ADDR_CTRL:   rd_mux = {6'b0, ctrl_q};
            ADDR_PERIOD: rd_mux = sh_period;
            ADDR_DUTY:   rd_mux = sh_duty;
            default:     rd_mux = status;
        endcase
    end

    // Register read data every cycle for the SPI side to resample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pwm_reg_ctrl.sv
// Self-checking bench for pwm_reg_ctrl against a register-level model.
module tb_pwm_reg_ctrl;

    localparam int unsigned SYNC = 2;

    logic       clk;
    logic       rst;
    logic       spi_wr_en;
    logic [1:0] spi_addr;
    logic [7:0] spi_data;
    logic [7:0] rd_data;
    logic       pwm_cycle_end;
    logic       pwm_en;
    logic       pwm_inv;
    logic [7:0] pwm_period;
    logic [7:0] pwm_duty;

    int n_vec;
    int n_err;

    // Model of the architectural register state
    logic [1:0] m_ctrl;
    logic [7:0] m_sh_per;
    logic [7:0] m_sh_duty;
    logic [7:0] m_act_per;
    logic [7:0] m_act_duty;
    logic       m_pend;
    logic [3:0] m_cnt;

    pwm_reg_ctrl #(
        .SYNC_STAGES (SYNC),
        .RST_PERIOD  (8'hFF),
        .RST_DUTY    (8'h80)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .spi_wr_en     (spi_wr_en),
        .spi_addr      (spi_addr),
        .spi_data      (spi_data),
        .rd_data       (rd_data),
        .pwm_cycle_end (pwm_cycle_end),
        .pwm_en        (pwm_en),
        .pwm_inv       (pwm_inv),
        .pwm_period    (pwm_period),
        .pwm_duty      (pwm_duty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_ctrl     = 2'b00;
        m_sh_per   = 8'hFF;
        m_sh_duty  = 8'h80;
        m_act_per  = 8'hFF;
        m_act_duty = 8'h80;
        m_pend     = 1'b0;
        m_cnt      = 4'd0;
    endfunction

    function automatic void m_commit(input logic [1:0] a, input logic [7:0] d);
        case (a)
            2'd0: m_ctrl = d[1:0];
            2'd1: begin m_sh_per = d; m_pend = 1'b1; end
            2'd2: begin m_sh_duty = d; m_pend = 1'b1; end
            default: ;
        endcase
        if (a != 2'd3) m_cnt = m_cnt + 4'd1;
    endfunction

    function automatic void m_boundary();
        if (m_pend) begin
            m_act_per  = m_sh_per;
            m_act_duty = m_sh_duty;
            m_pend     = 1'b0;
        end
    endfunction

    function automatic logic [7:0] exp_duty();
        return (m_act_duty < m_act_per) ? m_act_duty : m_act_per;
    endfunction

    function automatic logic [7:0] exp_read(input logic [1:0] a);
        case (a)
            2'd0:    return {6'b0, m_ctrl};
            2'd1:    return m_sh_per;
            2'd2:    return m_sh_duty;
            default: return {m_cnt, 2'b00, (m_act_duty > m_act_per), m_pend};
        endcase
    endfunction

    task automatic chk_all(input string tag);
        chk({tag, ".period"}, pwm_period, m_act_per);
        chk({tag, ".duty"}, pwm_duty, exp_duty());
        chk({tag, ".en"}, {7'b0, pwm_en}, {7'b0, m_ctrl[0]});
        chk({tag, ".inv"}, {7'b0, pwm_inv}, {7'b0, m_ctrl[1]});
        for (int a = 0; a < 4; a++) begin
            spi_addr = 2'(a);
            step();
            chk($sformatf("%s.rd%0d", tag, a), rd_data, exp_read(2'(a)));
        end
    endtask

    // Full write transaction: hold the strobe well past the commit, then settle
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        spi_addr  = a;
        spi_data  = d;
        spi_wr_en = 1'b1;
        repeat (8) step();
        spi_wr_en = 1'b0;
        repeat (SYNC + 4) step();
        m_commit(a, d);
        if (!m_ctrl[0]) m_boundary();
    endtask

    task automatic pulse_end();
        pwm_cycle_end = 1'b1;
        step();
        pwm_cycle_end = 1'b0;
        step();
        m_boundary();
    endtask

    initial begin
        logic [1:0] ra;
        logic [7:0] rdat;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        spi_wr_en = 1'b0;
        spi_addr = 2'd0;
        spi_data = 8'h00;
        pwm_cycle_end = 1'b0;
        m_reset();

        // Reset values
        repeat (3) step();
        chk("rst.rd_data", rd_data, 8'h00);
        chk("rst.period", pwm_period, 8'hFF);
        chk("rst.duty", pwm_duty, 8'h80);
        chk("rst.en", {7'b0, pwm_en}, 8'h00);
        rst = 1'b0;
        step();
        chk_all("rst");

        // PERIOD write while disabled: commit lands on the 4th edge after the
        // first sampling edge, active follows on the next edge
        spi_addr  = 2'd1;
        spi_data  = 8'h64;
        spi_wr_en = 1'b1;
        repeat (SYNC + 3) step();
        chk("lat.before", pwm_period, 8'hFF);
        step();
        chk("lat.after", pwm_period, 8'h64);
        repeat (4) step();
        spi_wr_en = 1'b0;
        repeat (SYNC + 4) step();
        m_commit(2'd1, 8'h64);
        m_boundary();
        chk_all("lat");

        // Enable+invert, then a DUTY write held off until a cycle end
        wr(2'd0, 8'hFF);
        wr(2'd2, 8'h20);
        chk_all("duty_pend");
        pulse_end();
        chk_all("duty_app");

        // Boundary coinciding with the PERIOD commit: old shadows applied, pending kept
        wr(2'd2, 8'h30);
        spi_addr  = 2'd1;
        spi_data  = 8'h10;
        spi_wr_en = 1'b1;
        repeat (SYNC + 2) step();
        pwm_cycle_end = 1'b1;
        step();
        pwm_cycle_end = 1'b0;
        m_boundary();
        m_commit(2'd1, 8'h10);
        chk("coin.period", pwm_period, 8'h64);
        chk("coin.duty", pwm_duty, 8'h30);
        repeat (3) step();
        spi_wr_en = 1'b0;
        repeat (SYNC + 4) step();
        chk_all("coin");
        pulse_end();
        chk_all("coin_app");

        // Clamp and STATUS write discard
        wr(2'd2, 8'h40);
        pulse_end();
        chk_all("clamp");
        wr(2'd3, 8'hA5);
        chk_all("st_wr");

        // Single-cycle strobe glitch is lost
        spi_addr  = 2'd1;
        spi_data  = 8'hEE;
        spi_wr_en = 1'b1;
        step();
        spi_wr_en = 1'b0;
        repeat (8) step();
        chk_all("glitch");

        // Randomised writes and cycle-end pulses
        for (int i = 0; i < 24; i++) begin
            ra   = 2'($urandom_range(0, 3));
            rdat = 8'($urandom);
            wr(ra, rdat);
            if ($urandom_range(0, 1) == 1) pulse_end();
            chk_all($sformatf("rnd%0d", i));
        end

        // Reset during WAIT_REL with the strobe still held
        spi_addr  = 2'd2;
        spi_data  = 8'h55;
        spi_wr_en = 1'b1;
        repeat (7) step();
        rst = 1'b1;
        step();
        m_reset();
        chk("mrst.period", pwm_period, 8'hFF);
        chk("mrst.duty", pwm_duty, 8'h80);
        chk("mrst.en", {7'b0, pwm_en}, 8'h00);
        chk("mrst.rd_data", rd_data, 8'h00);
        step();
        rst = 1'b0;
        repeat (8) step();
        spi_wr_en = 1'b0;
        repeat (SYNC + 4) step();
        m_commit(2'd2, 8'h55);
        m_boundary();
        chk_all("mrst");

        // Accepted-write counter wraps after 16 writes
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        m_reset();
        for (int i = 0; i < 15; i++) wr(2'd0, 8'h00);
        spi_addr = 2'd3;
        step();
        chk("wrap.15", rd_data, 8'hF0);
        wr(2'd0, 8'h00);
        chk_all("wrap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
